lsy201_uart_rx: RTL and testbench



---
 rtl/lsy201_uart_rx_if.sv | 11 +
 rtl/lsy201_uart_rx.sv | 193 +++++++++++++++++++
 tb/tb_lsy201_uart_rx.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/lsy201_uart_rx_if.sv
// FIFO write-side bundle between the LSY201 UART receiver (master) and the downstream byte FIFO (slave).
interface lsy201_uart_rx_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] datout;
  logic             wr;
  logic             full;

  modport master (output datout, output wr, input full);
  modport slave  (input datout, input wr, output full);
endinterface

// File: rtl/lsy201_uart_rx.sv
// 8N1 LSB-first UART receiver for the LSY201 camera link, feeding a downstream byte FIFO.
// Optional macro RX_GLITCH_FILTER_EN: 2-of-3 majority bit decisions and a 2-clk start qualifier.
module lsy201_uart_rx #(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD       = 38400,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATO_WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rxd,
  input  logic             clr_err,
  lsy201_uart_rx_if.master fifo,
  output logic             overrun,
  output logic             frame_err,
  output logic             busy
);

  localparam int unsigned DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int unsigned DIV_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int unsigned SC_W  = $clog2(OVERSAMPLE);
  localparam int unsigned BC_W  = $clog2(DATO_WIDTH + 1);
  localparam int unsigned MID   = OVERSAMPLE / 2 - 1;
`ifdef RX_GLITCH_FILTER_EN
  localparam int unsigned FIRST_DEC = MID + 1;
`else
  localparam int unsigned FIRST_DEC = MID;
`endif

  generate
    if (DIV < 2) begin : g_bad_div
      $error("lsy201_uart_rx: CLK_FREQ/(BAUD*OVERSAMPLE) must be at least 2");
    end
    if ((OVERSAMPLE < 8) || ((OVERSAMPLE % 2) != 0)) begin : g_bad_os
      $error("lsy201_uart_rx: OVERSAMPLE must be an even number >= 8");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    LINE_BREAK
  } state_t;

  state_t                state;
  logic                  sync1;
  logic                  sync2;
  logic                  rx_prev;
  logic [DIV_W-1:0]      div_cnt;
  logic [SC_W-1:0]       sample_cnt;
  logic [BC_W-1:0]       bit_cnt;
  logic [DATO_WIDTH-1:0] shift_reg;
  logic                  tick;
  logic                  decide;
  logic [SC_W-1:0]       dec_cnt;
  logic                  sample_bit;
  logic                  start_edge;

  // Synchroniser and edge history preset high so reset never looks like a start edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      sync1   <= rxd;
      sync2   <= sync1;
      rx_prev <= sync2;
    end
  end

`ifdef RX_GLITCH_FILTER_EN
  logic rx_prev2;
  logic samp_a;
  logic samp_b;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_prev2 <= 1'b1;
      samp_a   <= 1'b1;
      samp_b   <= 1'b1;
    end else begin
      rx_prev2 <= rx_prev;
      if (tick && (sample_cnt == dec_cnt - SC_W'(2))) samp_a <= sync2;
      if (tick && (sample_cnt == dec_cnt - SC_W'(1))) samp_b <= sync2;
    end
  end

  assign start_edge = rx_prev2 && !rx_prev && !sync2;
  assign sample_bit = (samp_a & samp_b) | (samp_a & sync2) | (samp_b & sync2);
`else
  assign start_edge = rx_prev && !sync2;
  assign sample_bit = sync2;
`endif

  // START decides half a bit in; every later decision is a full bit after the previous one.
  assign tick    = busy && (div_cnt == DIV_W'(DIV - 1));
  assign dec_cnt = (state == START) ? SC_W'(FIRST_DEC) : SC_W'(OVERSAMPLE - 1);
  assign decide  = tick && (sample_cnt == dec_cnt);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      div_cnt     <= '0;
      sample_cnt  <= '0;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      fifo.datout <= '0;
      fifo.wr     <= 1'b0;
      overrun     <= 1'b0;
      frame_err   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      fifo.wr <= 1'b0;
      if (clr_err) begin
        overrun   <= 1'b0;
        frame_err <= 1'b0;
      end
      if (!busy || tick) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
      if (tick) begin
        sample_cnt <= sample_cnt + 1'b1;
      end

      // Error sets come after the clear above so a simultaneous error wins.
      unique case (state)
        IDLE: begin
          if (start_edge) begin
            state      <= START;
            busy       <= 1'b1;
            sample_cnt <= '0;
            bit_cnt    <= '0;
          end
        end
        START: begin
          if (decide) begin
            sample_cnt <= '0;
            if (!sample_bit) begin
              state <= DATA;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        DATA: begin
          if (decide) begin
            sample_cnt <= '0;
            shift_reg  <= DATO_WIDTH'({sample_bit, shift_reg} >> 1);
            bit_cnt    <= bit_cnt + 1'b1;
            if (bit_cnt == BC_W'(DATO_WIDTH - 1)) begin
              state <= STOP;
            end
          end
        end
        STOP: begin
          if (decide) begin
            sample_cnt <= '0;
            if (sample_bit) begin
              state <= IDLE;
              busy  <= 1'b0;
              if (!fifo.full) begin
                fifo.datout <= shift_reg;
                fifo.wr     <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
              state     <= LINE_BREAK;
            end
          end
        end
        LINE_BREAK: begin
          if (sync2) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsy201_uart_rx.sv
// Self-checking bench for lsy201_uart_rx: directed camera-link scenarios plus randomized frames
// checked against a frame-level model of the expected FIFO writes and sticky flags.
module tb_lsy201_uart_rx;

  localparam int unsigned BAUD     = 38400;
  localparam int unsigned OS       = 16;
  localparam int unsigned DIV      = 4;
  localparam int unsigned CLK_FREQ = BAUD * OS * DIV;
  localparam int          BIT      = DIV * OS;

  logic clk     = 1'b0;
  logic rst     = 1'b1;
  logic rxd     = 1'b1;
  logic clr_err = 1'b0;
  logic overrun;
  logic frame_err;
  logic busy;

  lsy201_uart_rx_if #(.WIDTH(8)) fifo_bus ();

  lsy201_uart_rx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OS),
    .DATO_WIDTH(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rxd      (rxd),
    .clr_err  (clr_err),
    .fifo     (fifo_bus),
    .overrun  (overrun),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: bytes the FIFO should receive, last accepted byte, sticky flags.
  byte unsigned exp_q[$];
  logic [7:0]   exp_dat = 8'h00;
  logic         exp_ovr = 1'b0;
  logic         exp_fe  = 1'b0;
  int           n_checked = 0;

  // Write monitor records every strobe and any strobe longer than one clock.
  byte unsigned got_q[$];
  int           wide_pulses = 0;
  logic         wr_last = 1'b0;

  always @(negedge clk) begin
    if (fifo_bus.wr === 1'b1) got_q.push_back(fifo_bus.datout);
    if ((fifo_bus.wr === 1'b1) && wr_last) wide_pulses <= wide_pulses + 1;
    wr_last <= (fifo_bus.wr === 1'b1);
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkWrites(input string tag);
    int n;
    checkOutput({tag, "_wr_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = n_checked; i < n; i++) checkOutput({tag, "_wr_data"}, got_q[i], exp_q[i]);
    n_checked = n;
  endtask

  task automatic waitIdle();
    for (int i = 0; (i < 4 * BIT) && (busy !== 1'b0); i++) @(negedge clk);
  endtask

  task automatic checkState(input string tag);
    waitIdle();
    checkWrites(tag);
    checkOutput({tag, "_datout"}, fifo_bus.datout, exp_dat);
    checkOutput({tag, "_overrun"}, overrun, exp_ovr);
    checkOutput({tag, "_frame_err"}, frame_err, exp_fe);
    checkOutput({tag, "_busy"}, busy, 1'b0);
    checkOutput({tag, "_wr_width"}, wide_pulses, 0);
  endtask

  task automatic holdBit(input logic v);
    rxd = v;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [7:0] b, input logic stop_bit, input logic fifo_full);
    fifo_bus.full = fifo_full;
    holdBit(1'b0);
    for (int i = 0; i < 8; i++) holdBit(b[i]);
    holdBit(stop_bit);
    rxd = 1'b1;
    if (!stop_bit) begin
      exp_fe = 1'b1;
    end else if (fifo_full) begin
      exp_ovr = 1'b1;
    end else begin
      exp_q.push_back(b);
      exp_dat = b;
    end
  endtask

  task automatic pulseClear();
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    exp_ovr = 1'b0;
    exp_fe  = 1'b0;
  endtask

  initial begin
    logic [7:0] rb;
    logic       rstop;
    logic       rfull;
    int         gap;
    logic       prev_bad;

    fifo_bus.full = 1'b0;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_datout", fifo_bus.datout, 8'h00);
    checkOutput("reset_wr", fifo_bus.wr, 1'b0);
    checkOutput("reset_overrun", overrun, 1'b0);
    checkOutput("reset_frame_err", frame_err, 1'b0);
    checkOutput("reset_busy", busy, 1'b0);
    rst = 1'b1;
    repeat (10) @(negedge clk);

    $display("[TB] single frame 0xA5");
    applyStimulus(8'hA5, 1'b1, 1'b0);
    checkState("t1");

    $display("[TB] back-to-back frames 0xFF 0xD8");
    applyStimulus(8'hFF, 1'b1, 1'b0);
    applyStimulus(8'hD8, 1'b1, 1'b0);
    checkState("t2");

    $display("[TB] short low pulse");
    rxd = 1'b0;
    repeat (8) @(negedge clk);
    rxd = 1'b1;
    repeat (40) @(negedge clk);
    checkOutput("t3_busy_before_bit_end", busy, 1'b0);
    checkState("t3");

    $display("[TB] framing error then good frame");
    applyStimulus(8'h3C, 1'b0, 1'b0);
    repeat (2 * BIT) @(negedge clk);
    applyStimulus(8'h55, 1'b1, 1'b0);
    checkState("t4");
    pulseClear();
    checkOutput("t4_frame_err_cleared", frame_err, 1'b0);

    $display("[TB] overrun while full");
    applyStimulus(8'h12, 1'b1, 1'b1);
    checkState("t5a");
    applyStimulus(8'h34, 1'b1, 1'b0);
    checkState("t5b");

    $display("[TB] reset in the middle of a frame");
    holdBit(1'b0);
    holdBit(1'b1);
    holdBit(1'b0);
    holdBit(1'b0);
    rxd = 1'b0;
    repeat (BIT / 2) @(negedge clk);
    rst = 1'b0;
    #1;
    exp_dat = 8'h00;
    exp_ovr = 1'b0;
    exp_fe  = 1'b0;
    checkOutput("t6_rst_datout", fifo_bus.datout, exp_dat);
    checkOutput("t6_rst_wr", fifo_bus.wr, 1'b0);
    checkOutput("t6_rst_overrun", overrun, exp_ovr);
    checkOutput("t6_rst_frame_err", frame_err, exp_fe);
    checkOutput("t6_rst_busy", busy, 1'b0);
    rxd = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (BIT) @(negedge clk);
    applyStimulus(8'h7E, 1'b1, 1'b0);
    checkState("t6");

`ifdef RX_GLITCH_FILTER_EN
    $display("[TB] glitch in bit 3 of 0x00");
    fifo_bus.full = 1'b0;
    holdBit(1'b0);
    for (int i = 0; i < 3; i++) holdBit(1'b0);
    rxd = 1'b0;
    repeat (BIT / 2) @(negedge clk);
    rxd = 1'b1;
    @(negedge clk);
    rxd = 1'b0;
    repeat (BIT / 2 - 1) @(negedge clk);
    for (int i = 4; i < 8; i++) holdBit(1'b0);
    holdBit(1'b1);
    exp_q.push_back(8'h00);
    exp_dat = 8'h00;
    checkState("t7_glitch");
`endif

    $display("[TB] randomized frames");
    prev_bad = 1'b0;
    for (int k = 0; k < 14; k++) begin
      rb    = 8'($urandom);
      rstop = ($urandom_range(0, 5) != 0);
      rfull = ($urandom_range(0, 3) == 0);
      gap   = prev_bad ? int'($urandom_range(1, 2)) : int'($urandom_range(0, 2));
      rxd = 1'b1;
      repeat (gap * BIT) @(negedge clk);
      applyStimulus(rb, rstop, rfull);
      checkState("rand");
      prev_bad = !rstop;
      if (exp_ovr || exp_fe) pulseClear();
    end
    checkState("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
